exec_alu: RTL and testbench
===========================

# exec_alu

Execute-stage integer arithmetic unit of the multi-cycle RV32 core. It computes RV32I ALU results, branch comparisons and RV32M multiply/divide/remainder on two 32-bit operands. Results are registered. Single-cycle ops finish on the enabling edge. Multiply/divide ops iterate over 32 clock cycles and hold `busy` high so the core FSM stalls the EXECUTE stage.

## Interface
- No parameters.
- `clk` input 1: the single system clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `enable` input 1: high while the EXECUTE stage is active and the instruction uses the ALU.
- `op` input 5: operation select (encoding below).
- `a` input 32: operand A (register rs1 or PC).
- `b` input 32: operand B (register rs2 or immediate).
- `out` output 32: registered result; holds its value until the next completed operation.
- `busy` output 1: combinational; high while a multi-cycle op is unfinished.
- `fault` output 1: combinational; `enable` AND illegal `op`.

## Operation
- Op encoding:
  - 0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA
  - 8 OR, 9 AND, 10 EQ, 11 NE, 12 LT, 13 GE, 14 LTU, 15 GEU
  - 16 MUL, 17 MULH, 18 MULHSU, 19 MULHU, 20 DIV, 21 DIVU, 22 REM, 23 REMU
  - 24–31 illegal.
- Arithmetic is modulo 2^32. Shift amount is `b[4:0]`. SRA replicates `a[31]`.
- SLT/SLTU and comparisons 10–15 return 1 or 0 in bit 0, with bits 31:1 zero. The core uses `out[0]` as the branch-taken flag.
- MUL returns the low 32 bits of the product.
- MULH/MULHSU/MULHU return the high 32 bits of the signed×signed, signed×unsigned and unsigned×unsigned 64-bit product.
- Division follows RISC-V rules and never faults:
  - divide by zero: quotient 0xFFFFFFFF, remainder = `a`;
  - signed overflow (0x80000000 / −1): quotient 0x80000000, remainder 0.
- Multi-cycle ops (16–23) use a radix-2 iterative shift-add multiplier and a restoring divider. Signed operands are converted to magnitudes, and the result sign is fixed after the last iteration.
- Illegal op: `fault` high while enabled; `out` is unchanged; no multi-cycle state starts.
- State: IDLE, RUN (iteration counter 0–31), DONE.
  - IDLE → DONE on an enabled edge with a single-cycle op; `out` is written at that edge.
  - IDLE → RUN on an enabled edge with a multi-cycle op; operands are captured.
  - RUN → DONE after the 32nd iteration edge; `out` is written.
  - DONE → IDLE on any edge with `enable` low.
  - In DONE with `enable` high, nothing is recomputed.
- `busy` = `enable` AND multi-cycle op AND state != DONE.
- Operands and `op` must stay stable while `busy` is high. Operands are captured in RUN, so later changes do not affect the result.

## Timing
- Reset asserted: `out`=0, state IDLE, counter 0. `busy`=0 and `fault`=0 while `enable` is low.
- Reset mid-operation aborts the iteration; `busy` drops immediately via the state change.
- Single-cycle op: `busy` stays 0. Enable rises before edge E0; `out` is valid after E0.
- Multi-cycle op: `busy` is high from enable rising until edge E32.
  - E0 loads the operands; E1..E32 are the 32 iterations.
  - `out` is valid and `busy` is low after E32. The FSM advances on E33.
- `enable` must be low for at least one edge between consecutive operations; this is guaranteed by the DECODE/WRITE_BACK stages.
- `out` is stable whenever `enable` is low, for MEMORY address and write-back use.

## Test plan
- Single-cycle ops:
  - ADD 0xFFFFFFFF+1 → `out`=0 after one edge, `busy` never high.
  - SUB 0−1 → 0xFFFFFFFF.
  - SRA 0x80000000 by 4 → 0xF8000000.
- Compares:
  - LT −1 vs 1 → 1; LTU −1 vs 1 → 0.
  - EQ 5,5 → 1; GEU 0,0xFFFFFFFF → 0; bits 31:1 are always 0.
- Multiply:
  - MUL 0x12345678×0x10 → 0x23456780.
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHSU −1×0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - `busy` high exactly 33 cycles.
- Divide:
  - DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF.
  - DIVU 7/0 → 0xFFFFFFFF; REM 7/0 → 7.
  - DIV 0x80000000/−1 → 0x80000000 with REM 0.
  - `fault` stays 0 throughout.
- Illegal op 25 with `enable`=1 → `fault`=1, `out` unchanged, `busy`=0; `fault` clears when `enable` drops.
- Assert reset during cycle 10 of a DIVU → `busy`=0 and `out`=0 at once; a following ADD 2+3 → 5.

Source files
------------

// File: rtl/exec_alu.sv
// exec_alu: execute-stage integer unit of the multi-cycle RV32 core.
// Single-cycle RV32I ALU and branch-compare ops finish on the enabling edge.
// RV32M multiply/divide ops iterate for 32 cycles using a radix-2 shift-add
// multiplier and a restoring divider that work on operand magnitudes.
module exec_alu (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [4:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        busy,
  output logic        fault
);

  localparam int DATA_W = 32;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [4:0]        cnt;

  logic              is_mc;
  logic              illegal;

  // Magnitude-domain operands and sign bookkeeping captured on the load edge
  logic              a_neg, b_neg;
  logic [DATA_W-1:0] a_mag, b_mag;

  // Iteration registers: hi = partial product / partial remainder,
  // lo = multiplier bits / dividend bits turning into quotient bits,
  // m  = multiplicand / divisor.
  logic [DATA_W-1:0] hi_p1, lo_p1, m_p1;
  logic              neg_q_p1, neg_r_p1;
  logic [2:0]        sel_p1;

  logic [DATA_W-1:0] hi_nx, lo_nx;
  logic [DATA_W:0]   mul_sum;
  logic [DATA_W:0]   div_r;
  logic [DATA_W-1:0] div_diff;
  logic [63:0]       prod;
  logic [DATA_W-1:0] mc_res;

  assign is_mc   = op[4] & ~op[3];
  assign illegal = op[4] &  op[3];

  // Two's-complement negation applied conditionally when fixing result signs
  function automatic logic [63:0] sign_fix64(input logic neg, input logic [63:0] v);
    return neg ? (~v + 64'd1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] sign_fix32(input logic neg, input logic [DATA_W-1:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

  function automatic logic [DATA_W-1:0] alu_single(input logic [4:0] f,
                                                   input logic [DATA_W-1:0] x,
                                                   input logic [DATA_W-1:0] y);
    logic signed [DATA_W-1:0] xs, ys;
    logic [DATA_W-1:0]        r;
    xs = x;
    ys = y;
    case (f)
      5'd0:    r = x + y;
      5'd1:    r = x - y;
      5'd2:    r = x << y[4:0];
      5'd3:    r = {31'd0, xs < ys};
      5'd4:    r = {31'd0, x < y};
      5'd5:    r = x ^ y;
      5'd6:    r = x >> y[4:0];
      5'd7:    r = $unsigned(xs >>> y[4:0]);
      5'd8:    r = x | y;
      5'd9:    r = x & y;
      5'd10:   r = {31'd0, x == y};
      5'd11:   r = {31'd0, x != y};
      5'd12:   r = {31'd0, xs < ys};
      5'd13:   r = {31'd0, xs >= ys};
      5'd14:   r = {31'd0, x < y};
      5'd15:   r = {31'd0, x >= y};
      default: r = '0;
    endcase
    return r;
  endfunction

  // Operand sign detection: MULH/MULHSU/DIV/REM treat a as signed, MULH/DIV/REM treat b as signed
  always_comb begin
    a_neg = a[31] & ((op[2:0] == 3'd1) | (op[2:0] == 3'd2) | (op[2:0] == 3'd4) | (op[2:0] == 3'd6));
    b_neg = b[31] & ((op[2:0] == 3'd1) | (op[2:0] == 3'd4) | (op[2:0] == 3'd6));
    a_mag = sign_fix32(a_neg, a);
    b_mag = sign_fix32(b_neg, b);
  end

  // One shift-add or restore-subtract step, plus final sign correction
  always_comb begin
    mul_sum  = {1'b0, hi_p1} + (lo_p1[0] ? {1'b0, m_p1} : '0);
    div_r    = {hi_p1, lo_p1[31]};
    div_diff = div_r[DATA_W-1:0] - m_p1;
    if (!sel_p1[2]) begin
      hi_nx = mul_sum[DATA_W:1];
      lo_nx = {mul_sum[0], lo_p1[DATA_W-1:1]};
    end else if (div_r >= {1'b0, m_p1}) begin
      hi_nx = div_diff;
      lo_nx = {lo_p1[DATA_W-2:0], 1'b1};
    end else begin
      hi_nx = div_r[DATA_W-1:0];
      lo_nx = {lo_p1[DATA_W-2:0], 1'b0};
    end
    prod = sign_fix64(neg_q_p1, {hi_nx, lo_nx});
    if (!sel_p1[2])
      mc_res = (sel_p1[1:0] == 2'd0) ? prod[31:0] : prod[63:32];
    else if (sel_p1[1])
      mc_res = sign_fix32(neg_r_p1, hi_nx);
    else
      mc_res = sign_fix32(neg_q_p1, lo_nx);
  end

  // Iteration datapath: load magnitudes on the start edge, step once per RUN cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && enable && is_mc) begin
      hi_p1  <= '0;
      sel_p1 <= op[2:0];
      if (!op[2]) begin
        m_p1     <= a_mag;
        lo_p1    <= b_mag;
        neg_q_p1 <= a_neg ^ b_neg;
        neg_r_p1 <= 1'b0;
      end else begin
        m_p1     <= b_mag;
        lo_p1    <= a_mag;
        // Divide by zero must yield all-ones regardless of dividend sign
        neg_q_p1 <= (a_neg ^ b_neg) & (b != '0);
        neg_r_p1 <= a_neg;
      end
    end else if (state == RUN) begin
      hi_p1 <= hi_nx;
      lo_p1 <= lo_nx;
    end
  end

  // Control FSM and registered result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      out   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable && !illegal) begin
            if (is_mc) begin
              state <= RUN;
              cnt   <= '0;
            end else begin
              out   <= alu_single(op, a, b);
              state <= DONE;
            end
          end
        end
        RUN: begin
          cnt <= cnt + 5'd1;
          if (cnt == 5'd31) begin
            out   <= mc_res;
            state <= DONE;
            cnt   <= '0;
          end
        end
        DONE: begin
          if (!enable)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy  = reset & enable & is_mc & (state != DONE);
  assign fault = enable & illegal;

endmodule

// File: tb/tb_exec_alu.sv
// Testbench for exec_alu: directed cases plus randomized ops checked against
// a plain-arithmetic reference model.
module tb_exec_alu;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [4:0]  op;
  logic [31:0] a, b;
  logic [31:0] out;
  logic        busy;
  logic        fault;

  int total;
  int bad;

  exec_alu dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .op     (op),
    .a      (a),
    .b      (b),
    .out    (out),
    .busy   (busy),
    .fault  (fault)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y);
    int          xi, yi;
    longint      sx, sy, ux, uy;
    logic [63:0] p;
    xi = $signed(x);
    yi = $signed(y);
    sx = longint'(xi);
    sy = longint'(yi);
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    case (f)
      5'd0:  return x + y;
      5'd1:  return x - y;
      5'd2:  return x << y[4:0];
      5'd3:  return (xi < yi) ? 32'd1 : 32'd0;
      5'd4:  return (x < y) ? 32'd1 : 32'd0;
      5'd5:  return x ^ y;
      5'd6:  return x >> y[4:0];
      5'd7:  return 32'(xi >>> y[4:0]);
      5'd8:  return x | y;
      5'd9:  return x & y;
      5'd10: return (x == y) ? 32'd1 : 32'd0;
      5'd11: return (x != y) ? 32'd1 : 32'd0;
      5'd12: return (xi < yi) ? 32'd1 : 32'd0;
      5'd13: return (xi >= yi) ? 32'd1 : 32'd0;
      5'd14: return (x < y) ? 32'd1 : 32'd0;
      5'd15: return (x >= y) ? 32'd1 : 32'd0;
      5'd16: begin p = ux * uy; return p[31:0]; end
      5'd17: begin p = sx * sy; return p[63:32]; end
      5'd18: begin p = sx * uy; return p[63:32]; end
      5'd19: begin p = ux * uy; return p[63:32]; end
      5'd20: begin
        if (y == 0) return 32'hFFFFFFFF;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'h80000000;
        return 32'(xi / yi);
      end
      5'd21: return (y == 0) ? 32'hFFFFFFFF : x / y;
      5'd22: begin
        if (y == 0) return x;
        if (x == 32'h80000000 && y == 32'hFFFFFFFF) return 32'd0;
        return 32'(xi % yi);
      end
      5'd23: return (y == 0) ? x : x % y;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0:       return 32'd0;
      1:       return 32'hFFFFFFFF;
      2:       return 32'h80000000;
      3:       return 32'd1;
      4:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Drives one operation starting just after a rising edge; returns the result
  // plus the number of sampled cycles with busy / fault high.
  task automatic run_op(input logic [4:0] f, input logic [31:0] x, input logic [31:0] y,
                        output logic [31:0] res, output int bc, output int fc, output bit to);
    int n;
    bc = 0; fc = 0; to = 0; n = 0;
    op = f; a = x; b = y; enable = 1'b1;
    #1;
    if (busy) bc++;
    if (fault) fc++;
    do begin
      @(posedge clk); #1;
      n++;
      if (busy) bc++;
      if (fault) fc++;
      a = $urandom; b = $urandom;  // operands are captured, so later changes must not matter
      a = (f >= 5'd16) ? a : x;
      b = (f >= 5'd16) ? b : y;
    end while (busy && n < 40);
    to  = busy;
    res = out;
    enable = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    total++; if (out !== 32'd0) begin bad++; $display("FAIL reset_out: got %h want %h", out, 32'd0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL reset_fault: got %b want 0", fault); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    total++; if (out !== 32'd0) begin bad++; $display("FAIL post_reset_out: got %h want %h", out, 32'd0); end
  endtask

  task automatic test_single();
    logic [4:0]  f_t [3] = '{5'd0, 5'd1, 5'd7};
    logic [31:0] a_t [3] = '{32'hFFFFFFFF, 32'd0, 32'h80000000};
    logic [31:0] b_t [3] = '{32'd1, 32'd1, 32'd4};
    logic [31:0] e_t [3] = '{32'd0, 32'hFFFFFFFF, 32'hF8000000};
    logic [31:0] res, x, y;
    logic [4:0]  f;
    int bc, fc;
    bit to;
    for (int i = 0; i < 3; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], res, bc, fc, to);
      total++; if (res !== e_t[i]) begin bad++; $display("FAIL single_dir%0d: got %h want %h", i, res, e_t[i]); end
      total++; if (bc !== 0) begin bad++; $display("FAIL single_busy%0d: got %0d want 0", i, bc); end
    end
    for (int i = 0; i < 20; i++) begin
      f = 5'($urandom_range(0, 9)); x = rnd_operand(); y = rnd_operand();
      run_op(f, x, y, res, bc, fc, to);
      total++; if (res !== model(f, x, y) || bc !== 0)
        begin bad++; $display("FAIL single_rnd op=%0d a=%h b=%h: got %h busy=%0d want %h busy=0", f, x, y, res, bc, model(f, x, y)); end
    end
  endtask

  task automatic test_compare();
    logic [4:0]  f_t [4] = '{5'd12, 5'd14, 5'd10, 5'd15};
    logic [31:0] a_t [4] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'd5, 32'd0};
    logic [31:0] b_t [4] = '{32'd1, 32'd1, 32'd5, 32'hFFFFFFFF};
    logic [31:0] e_t [4] = '{32'd1, 32'd0, 32'd1, 32'd0};
    logic [31:0] res, x, y;
    logic [4:0]  f;
    int bc, fc;
    bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], res, bc, fc, to);
      total++; if (res !== e_t[i]) begin bad++; $display("FAIL cmp_dir%0d: got %h want %h", i, res, e_t[i]); end
    end
    for (int i = 0; i < 20; i++) begin
      f = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(3, 4)) : 5'($urandom_range(10, 15));
      x = rnd_operand(); y = ($urandom_range(0, 3) == 0) ? x : rnd_operand();
      run_op(f, x, y, res, bc, fc, to);
      total++; if (res[31:1] !== 31'd0) begin bad++; $display("FAIL cmp_hibits op=%0d: got %h want 0", f, res[31:1]); end
      total++; if (res !== model(f, x, y))
        begin bad++; $display("FAIL cmp_rnd op=%0d a=%h b=%h: got %h want %h", f, x, y, res, model(f, x, y)); end
    end
  endtask

  task automatic test_mul();
    logic [4:0]  f_t [4] = '{5'd16, 5'd17, 5'd18, 5'd19};
    logic [31:0] a_t [4] = '{32'h12345678, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] b_t [4] = '{32'h10, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e_t [4] = '{32'h23456780, 32'h40000000, 32'hFFFFFFFF, 32'hFFFFFFFE};
    logic [31:0] res, x, y;
    logic [4:0]  f;
    int bc, fc;
    bit to;
    for (int i = 0; i < 4; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], res, bc, fc, to);
      total++; if (to) begin bad++; $display("FAIL mul_timeout%0d: busy still %b want 0", i, busy); end
      total++; if (res !== e_t[i]) begin bad++; $display("FAIL mul_dir%0d: got %h want %h", i, res, e_t[i]); end
      total++; if (bc !== 33) begin bad++; $display("FAIL mul_busy_cycles%0d: got %0d want 33", i, bc); end
    end
    total++; if (out !== 32'hFFFFFFFE) begin bad++; $display("FAIL mul_out_hold: got %h want %h", out, 32'hFFFFFFFE); end
    for (int i = 0; i < 12; i++) begin
      f = 5'($urandom_range(16, 19)); x = rnd_operand(); y = rnd_operand();
      run_op(f, x, y, res, bc, fc, to);
      total++; if (res !== model(f, x, y) || bc !== 33)
        begin bad++; $display("FAIL mul_rnd op=%0d a=%h b=%h: got %h busy=%0d want %h busy=33", f, x, y, res, bc, model(f, x, y)); end
    end
  endtask

  task automatic test_div();
    logic [4:0]  f_t [6] = '{5'd20, 5'd22, 5'd21, 5'd22, 5'd20, 5'd22};
    logic [31:0] a_t [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'h80000000, 32'h80000000};
    logic [31:0] b_t [6] = '{32'd2, 32'd2, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] e_t [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd7, 32'h80000000, 32'd0};
    logic [31:0] res, x, y;
    logic [4:0]  f;
    int bc, fc, fsum;
    bit to;
    fsum = 0;
    for (int i = 0; i < 6; i++) begin
      run_op(f_t[i], a_t[i], b_t[i], res, bc, fc, to);
      fsum += fc;
      total++; if (res !== e_t[i] || to) begin bad++; $display("FAIL div_dir%0d: got %h want %h", i, res, e_t[i]); end
    end
    for (int i = 0; i < 16; i++) begin
      f = 5'($urandom_range(20, 23)); x = rnd_operand(); y = rnd_operand();
      run_op(f, x, y, res, bc, fc, to);
      fsum += fc;
      total++; if (res !== model(f, x, y) || bc !== 33)
        begin bad++; $display("FAIL div_rnd op=%0d a=%h b=%h: got %h busy=%0d want %h busy=33", f, x, y, res, bc, model(f, x, y)); end
    end
    total++; if (fsum !== 0) begin bad++; $display("FAIL div_fault: got %0d fault cycles want 0", fsum); end
  endtask

  task automatic test_illegal();
    logic [31:0] res;
    int bc, fc;
    bit to;
    run_op(5'd0, 32'd10, 32'd20, res, bc, fc, to);
    op = 5'd25; a = 32'd1; b = 32'd2; enable = 1'b1;
    #1;
    total++; if (fault !== 1'b1) begin bad++; $display("FAIL illegal_fault: got %b want 1", fault); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL illegal_busy: got %b want 0", busy); end
    @(posedge clk); #1;
    total++; if (out !== 32'd30) begin bad++; $display("FAIL illegal_out: got %h want %h", out, 32'd30); end
    enable = 1'b0;
    #1;
    total++; if (fault !== 1'b0) begin bad++; $display("FAIL illegal_fault_clear: got %b want 0", fault); end
    @(posedge clk); #1;
    run_op(5'd9, 32'hF0F0F0F0, 32'h0FF00FF0, res, bc, fc, to);
    total++; if (res !== 32'h00F000F0) begin bad++; $display("FAIL illegal_after: got %h want %h", res, 32'h00F000F0); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] res;
    int bc, fc;
    bit to;
    run_op(5'd0, 32'd1, 32'd1, res, bc, fc, to);
    op = 5'd21; a = 32'd1000; b = 32'd7; enable = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL mid_busy_before: got %b want 1", busy); end
    reset = 1'b0; enable = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_busy_reset: got %b want 0", busy); end
    total++; if (out !== 32'd0) begin bad++; $display("FAIL mid_out_reset: got %h want 0", out); end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_op(5'd0, 32'd2, 32'd3, res, bc, fc, to);
    total++; if (res !== 32'd5) begin bad++; $display("FAIL mid_add_after: got %h want %h", res, 32'd5); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] res, x, y;
    logic [4:0]  f;
    int bc, fc;
    bit to;
    for (int i = 0; i < 30; i++) begin
      f = 5'($urandom_range(0, 23)); x = rnd_operand(); y = rnd_operand();
      run_op(f, x, y, res, bc, fc, to);
      total++; if (res !== model(f, x, y) || bc !== ((f >= 5'd16) ? 33 : 0) || fc !== 0)
        begin bad++; $display("FAIL b2b op=%0d a=%h b=%h: got %h busy=%0d fault=%0d want %h", f, x, y, res, bc, fc, model(f, x, y)); end
      total++; if (out !== res) begin bad++; $display("FAIL b2b_hold op=%0d: got %h want %h", f, out, res); end
    end
  endtask

  initial begin
    total = 0; bad = 0;
    clk = 1'b0; reset = 1'b0; enable = 1'b0; op = '0; a = '0; b = '0;
    #12;
    test_reset();
    test_single();
    test_compare();
    test_mul();
    test_div();
    test_illegal();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
